// File: rtl/perf_counter_mc_if.sv
// perf_counter_mc_if
//   Avalon-MM control-slave bundle for the multi-section performance counter.
//   master modport : driven by the CPU side (or a testbench).
//   slave  modport : consumed by perf_counter_mc.
//   Signals: address[5:0] word address, begintransfer, read, write,
//            writedata[31:0], readdata[31:0] (registered), irq.
interface perf_counter_mc_if;
  logic [5:0]  address;
  logic        begintransfer;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, begintransfer, read, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, begintransfer, read, write, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/perf_counter_mc.sv
// perf_counter_mc
//   Parametrised multi-section performance counter on an Avalon-MM slave.
//   Software brackets code regions with GO/STOP writes; each section counts
//   elapsed clk cycles (time) and region entries (events).
//
//   Ports:
//     clk      : clock
//     reset_n  : asynchronous, active-low reset
//     bus      : perf_counter_mc_if.slave (address, begintransfer, read,
//                write, writedata, readdata, irq)
//
//   Parameters: NUM_SECTIONS (1..15), TIME_WIDTH (33..64), EVENT_WIDTH (1..32)
//
//   Register map, section s at base B = 4*s:
//     B+0  W: STOP   R: time[31:0] (a read strobe latches time[TW-1:32] in shadow)
//     B+1  W: GO     R: shadow (high time word captured by the last B+0 read)
//     B+2  W: CLEAR  R: event count
//     B+3  R: status {event_ovf, time_ovf, enable}
//     60   R: ID {0x5A, EVENT_WIDTH, TIME_WIDTH, NUM_SECTIONS}
//     61   R/W: irq mask (only with PERF_COUNTER_IRQ_EN)
//   A STOP to address 0 with writedata[0]=1 is a global reset of all sections.
//
//   Optional feature macro: PERF_COUNTER_IRQ_EN (mask register + registered irq).
//   Without it address 61 reads 0 and irq is tied low.
module perf_counter_mc #(
  parameter int NUM_SECTIONS = 8,
  parameter int TIME_WIDTH   = 64,
  parameter int EVENT_WIDTH  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  perf_counter_mc_if.slave  bus
);

  localparam int HI_WIDTH = TIME_WIDTH - 32;

  // Bus strobe decode
  logic       w_wr_s;
  logic       w_rd_s;
  logic [3:0] w_sec;
  logic [1:0] w_off;
  logic       w_global_reset;
  logic       w_go0;
  logic       w_global_enable;

  assign w_wr_s = bus.write & bus.begintransfer;
  assign w_rd_s = bus.read  & bus.begintransfer;
  assign w_sec  = bus.address[5:2];
  assign w_off  = bus.address[1:0];

  assign w_global_reset = w_wr_s & (bus.address == 6'd0) & bus.writedata[0];
  assign w_go0          = w_wr_s & (bus.address == 6'd1);

  // Per-section state exported as 16-entry vectors; entries beyond
  // NUM_SECTIONS are constant zero so the read mux needs no range check.
  logic [15:0][TIME_WIDTH-1:0]  w_time;
  logic [15:0][EVENT_WIDTH-1:0] w_event;
  logic [15:0][31:0]            w_shadow;
  logic [15:0]                  w_enable;
  logic [15:0]                  w_time_ovf;
  logic [15:0]                  w_event_ovf;

  // Section 0 gates everyone: a GO to section 0 opens the gate in the same
  // cycle so its own event is always counted.
  assign w_global_enable = w_enable[0] | w_go0;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sec
      if (gi < NUM_SECTIONS) begin : g_on
        logic                   r_enable;
        logic [TIME_WIDTH-1:0]  r_time;
        logic [EVENT_WIDTH-1:0] r_event;
        logic [HI_WIDTH-1:0]    r_shadow;
        logic                   r_time_ovf;
        logic                   r_event_ovf;

        logic w_hit;
        logic w_go;
        logic w_stop;
        logic w_clr;
        logic w_cap;
        logic w_time_inc;
        logic w_event_inc;

        assign w_hit       = (w_sec == 4'(gi));
        assign w_go        = w_wr_s & w_hit & (w_off == 2'd1);
        assign w_stop      = w_wr_s & w_hit & (w_off == 2'd0);
        assign w_clr       = w_wr_s & w_hit & (w_off == 2'd2);
        assign w_cap       = w_rd_s & w_hit & (w_off == 2'd0);
        assign w_time_inc  = r_enable & w_global_enable;
        assign w_event_inc = w_go & w_global_enable;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_enable    <= 1'b0;
            r_time      <= '0;
            r_event     <= '0;
            r_shadow    <= '0;
            r_time_ovf  <= 1'b0;
            r_event_ovf <= 1'b0;
          end else if (w_global_reset) begin
            r_enable    <= 1'b0;
            r_time      <= '0;
            r_event     <= '0;
            r_shadow    <= '0;
            r_time_ovf  <= 1'b0;
            r_event_ovf <= 1'b0;
          end else begin
            if (w_go) begin
              r_enable <= 1'b1;
            end else if (w_stop) begin
              r_enable <= 1'b0;
            end

            // Latch the high word with the low-word read so software sees
            // one coherent 64-bit sample.
            if (w_cap) begin
              r_shadow <= r_time[TIME_WIDTH-1:32];
            end

            // CLEAR beats any increment landing in the same cycle.
            if (w_clr) begin
              r_time      <= '0;
              r_event     <= '0;
              r_time_ovf  <= 1'b0;
              r_event_ovf <= 1'b0;
            end else begin
              if (w_time_inc) begin
                r_time <= r_time + 1'b1;
                if (&r_time) begin
                  r_time_ovf <= 1'b1;
                end
              end
              if (w_event_inc) begin
                r_event <= r_event + 1'b1;
                if (&r_event) begin
                  r_event_ovf <= 1'b1;
                end
              end
            end
          end
        end

        assign w_time[gi]      = r_time;
        assign w_event[gi]     = r_event;
        assign w_shadow[gi]    = 32'(r_shadow);
        assign w_enable[gi]    = r_enable;
        assign w_time_ovf[gi]  = r_time_ovf;
        assign w_event_ovf[gi] = r_event_ovf;
      end else begin : g_off
        assign w_time[gi]      = '0;
        assign w_event[gi]     = '0;
        assign w_shadow[gi]    = '0;
        assign w_enable[gi]    = 1'b0;
        assign w_time_ovf[gi]  = 1'b0;
        assign w_event_ovf[gi] = 1'b0;
      end
    end
  endgenerate

  // Optional interrupt: mask register and registered irq
`ifdef PERF_COUNTER_IRQ_EN
  logic [NUM_SECTIONS-1:0] r_mask;
  logic                    r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_s && (bus.address == 6'd61)) begin
        r_mask <= bus.writedata[NUM_SECTIONS-1:0];
      end
      r_irq <= |(r_mask & (w_time_ovf[NUM_SECTIONS-1:0] |
                           w_event_ovf[NUM_SECTIONS-1:0]));
    end
  end

  assign bus.irq = r_irq;
`else
  assign bus.irq = 1'b0;
`endif

  // Read mux: samples state before this edge's update
  logic [31:0] w_rdata_next;
  logic [31:0] r_readdata;

  always_comb begin
    w_rdata_next = 32'd0;
    if (bus.address == 6'd60) begin
      w_rdata_next = {8'h5A, 8'(EVENT_WIDTH), 8'(TIME_WIDTH), 8'(NUM_SECTIONS)};
`ifdef PERF_COUNTER_IRQ_EN
    end else if (bus.address == 6'd61) begin
      w_rdata_next = 32'(r_mask);
`endif
    end else begin
      case (w_off)
        2'd0:    w_rdata_next = w_time[w_sec][31:0];
        2'd1:    w_rdata_next = w_shadow[w_sec];
        2'd2:    w_rdata_next = 32'(w_event[w_sec]);
        default: w_rdata_next = {29'd0, w_event_ovf[w_sec], w_time_ovf[w_sec],
                                 w_enable[w_sec]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else begin
      r_readdata <= w_rdata_next;
    end
  end

  assign bus.readdata = r_readdata;

  // Only writedata[0] and the mask bits are meaningful.
  logic w_unused_wdata;
  assign w_unused_wdata = ^bus.writedata;

endmodule

// File: doc/perf_counter_mc.md
Name: perf_counter_mc

Overview:
- Parametrised multi-section Avalon-MM performance counter; next generation of the fixed 8-section, 64-bit Nios II perf counter.
- Software brackets code regions with GO/STOP writes. Each section counts elapsed clk cycles (time) and region entries (events).
- Adds configurable section count and widths, atomic 64-bit time reads, per-section clear, sticky overflow status and a global ID register.
- Sits on the system interconnect as a control slave beside the CPU data master.

Parameters:
- NUM_SECTIONS, 8, number of sections, 1..15.
- TIME_WIDTH, 64, time counter width, 33..64.
- EVENT_WIDTH, 32, event counter width, 1..32.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  6  word address
- begintransfer  in  1  first cycle of an Avalon transfer
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  overflow interrupt; tied to 0 when the optional feature is absent

Behaviour:
- Reset: every counter, enable, flag, shadow, mask, readdata and irq is 0.
- Strobes: wr_s = write & begintransfer; rd_s = read & begintransfer. Section s occupies base B = 4*s.
- Sections s >= NUM_SECTIONS and unmapped addresses read 0; writes to them are ignored.
- Section register map:
  - B+0 write = STOP, clears enable_s. Read = time[31:0]; a read with rd_s also copies time[TIME_WIDTH-1:32], zero-extended, into shadow_s in the same cycle.
  - B+1 write = GO, sets enable_s. Read = shadow_s.
  - B+2 write = CLEAR, zeroes time_s, event_s and the section's flags; enable_s is unchanged. Read = event_s, zero-extended.
  - B+3 read = status: bit0 enable_s, bit1 time overflow (sticky), bit2 event overflow (sticky), other bits 0. Writes ignored.
- Global registers:
  - 60 read = ID: [7:0] NUM_SECTIONS, [15:8] TIME_WIDTH, [23:16] EVENT_WIDTH, [31:24] 0x5A.
  - 61 read/write = irq mask [NUM_SECTIONS-1:0]; only present with the optional feature.
- global_enable = enable_0 | go_0 (go_0 = GO strobe to section 0).
- global_reset = STOP to address 0 with writedata[0]=1. It zeroes all counters, enables, flags and shadows in that cycle and has priority over all other updates.
- Time counter: increments each cycle while enable_s & global_enable. It starts the cycle after the GO write (enable is registered).
- Event counter: increments on go_s & global_enable. A GO to section 0 always counts. A GO to section s>0 while section 0 is stopped is not counted, but still sets enable_s.
- Wrap: a counter at all-ones that increments goes to 0 and sets its sticky overflow flag. Flags clear only via CLEAR, global_reset or reset.
- CLEAR on a running section: the counter is 0 after that edge and resumes incrementing the next cycle. CLEAR wins over an increment in the same cycle.
- GO while running: enable stays 1 and the event counter increments. STOP while stopped: no effect.
- readdata <= mux(address) every cycle, so data is valid 1 cycle after the address is presented. The read mux samples counter values before the same-edge update.
- Reads have no side effects other than the shadow capture on B+0.
- Reset asserted mid-count: everything returns to 0 asynchronously; no state survives.

Optional Feature:
- Macro: PERF_COUNTER_IRQ_EN.
- Defined:
  - Mask register at address 61 is implemented.
  - irq is registered: irq <= |(mask & (time_ovf | event_ovf)) per section.
  - irq deasserts the cycle after the causing flags are cleared or the mask bit is cleared.
- Undefined:
  - Address 61 reads 0 and ignores writes; irq is constant 0.
  - No mask or irq flops are synthesised.

Test Plan:
- Reset, then read address 60 with defaults -> readdata = 0x5A204008. All section registers read 0 and irq = 0.
- GO s0, wait 100 cycles, STOP s0 -> time0 low word = 100 ±1 (pin the exact value against the spec), event0 = 1, status0 = 0.
- Preload time_s via a bench force to 0x0000_0001_FFFF_FFFF while running. Read B+0, then B+1 -> B+1 returns 1 from the shadow even though time has since carried to high word 2.
- EVENT_WIDTH=4: 16 GO/STOP pairs on s1 with s0 running -> event1 = 0 and status1 bit2 = 1. Define PERF_COUNTER_IRQ_EN with mask bit1 set -> irq = 1; CLEAR s1 -> irq = 0 one cycle later.
- s0 and s2 running, CLEAR s2 -> s2 reads 0 and keeps counting; s0 unaffected. Write address 0 with writedata=1 -> all counters, enables and flags read 0.
- GO s3 with s0 stopped -> event3 = 0, enable3 = 1, time3 frozen. GO s0 -> time3 starts incrementing.
